// File: rtl/instr_enc_pkg.sv
// Shared definitions for the instruction word encoder: format encoding,
// opcodes and the encodable immediate ranges.
package instr_enc_pkg;

  typedef enum logic [1:0] {
    FMT_I   = 2'b00,
    FMT_S   = 2'b01,
    FMT_SB  = 2'b10,
    FMT_RSV = 2'b11
  } fmt_e;

  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_S  = 7'b0100011;
  localparam logic [6:0] OPC_SB = 7'b1100011;

  // I/SB immediates decode sign-extended, S immediates decode zero-extended
  localparam int IMM_SMIN = -2048;
  localparam int IMM_SMAX = 2047;
  localparam int IMM_UMIN = 0;
  localparam int IMM_UMAX = 4095;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer for I/S/SB words plus immediate range check.
// Range comparators exist only when INSTR_ENC_RANGE_CHECK_EN is defined.
module instr_pack
  import instr_enc_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        range_err
);

  always_comb begin
    instr = '0;
    case (fmt_e'(fmt))
      FMT_I:   instr = {imm[11:0], rs1, funct3, rd, OPC_I};
      FMT_S:   instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_S};
      FMT_SB:  instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_SB};
      default: instr = '0;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic signed [31:0] simm;
  assign simm = signed'(imm);

  always_comb begin
    range_err = 1'b0;
    case (fmt_e'(fmt))
      FMT_I, FMT_SB: range_err = (simm < IMM_SMIN) || (simm > IMM_SMAX);
      FMT_S:         range_err = (simm < IMM_UMIN) || (simm > IMM_UMAX);
      default:       range_err = 1'b0;
    endcase
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:12];
  assign range_err     = 1'b0;
`endif

endmodule

// File: rtl/instr_word_encoder.sv
// Instruction word encoder: packs requests, tags them with an auto-incrementing
// write address and buffers them in a 2-entry FIFO. Option: INSTR_ENC_RANGE_CHECK_EN.
module instr_word_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              addr_clr,
  output logic              err_fmt,
  output logic              err_range
);

  logic [31:0]       instr_mem [2];
  logic [ADDR_W-1:0] addr_mem  [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic [1:0]        count_next;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       packed_instr;
  logic              range_err;
  logic              accept;
  logic              is_rsv;
  logic              push;
  logic              pop;

  instr_pack u_pack (
    .fmt       (in_fmt),
    .rd        (in_rd),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .funct3    (in_funct3),
    .imm       (in_imm),
    .instr     (packed_instr),
    .range_err (range_err)
  );

  assign accept    = in_valid && in_ready;
  assign is_rsv    = (fmt_e'(in_fmt) == FMT_RSV);
  assign push      = accept && !is_rsv;
  assign pop       = out_valid && out_ready;
  // A same-cycle clear hands address 0 to the request being accepted
  assign word_addr = addr_clr ? '0 : wr_addr;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      wr_addr   <= '0;
      in_ready  <= 1'b0;
      err_fmt   <= 1'b0;
      err_range <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        instr_mem[i] <= '0;
        addr_mem[i]  <= '0;
      end
    end else begin
      count    <= count_next;
      in_ready <= (count_next < 2'd2);
      if (push) begin
        instr_mem[wr_ptr] <= packed_instr;
        addr_mem[wr_ptr]  <= word_addr;
        wr_ptr            <= ~wr_ptr;
        wr_addr           <= word_addr + ADDR_W'(1);
      end else if (addr_clr) begin
        wr_addr <= '0;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      err_fmt   <= (err_fmt && !addr_clr) || (accept && is_rsv);
      err_range <= (err_range && !addr_clr) || (push && range_err);
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_instr = instr_mem[rd_ptr];
  assign out_addr  = addr_mem[rd_ptr];

endmodule

// File: tb/tb_instr_word_encoder.sv
// Directed scoreboard bench for instr_word_encoder (ADDR_W=2 to exercise wrap).
module tb_instr_word_encoder;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_fmt;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              addr_clr;
  logic              err_fmt;
  logic              err_range;

  typedef struct {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t              sb[$];
  logic [ADDR_W-1:0] exp_addr;
  int                tests = 0;
  int                fails = 0;
  logic              exp_range_flag;

  instr_word_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .addr_clr  (addr_clr),
    .err_fmt   (err_fmt),
    .err_range (err_range)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: every handshaken word must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", out_instr, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_instr", out_instr, e.instr);
        chk("out_addr", 32'(out_addr), 32'(e.addr));
      end
    end
  end

  task automatic send(input logic [1:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                      input logic [31:0] exp_instr);
    bit   accepted = 0;
    exp_t e;
    in_valid  = 1'b1;
    in_fmt    = fmt;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_imm    = imm;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        accepted = 1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
    else if (fmt != 2'b11) begin
      e.instr  = exp_instr;
      e.addr   = exp_addr;
      sb.push_back(e);
      exp_addr = exp_addr + 1'b1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #2;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
`ifdef INSTR_ENC_RANGE_CHECK_EN
    exp_range_flag = 1'b1;
`else
    exp_range_flag = 1'b0;
`endif
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; addr_clr = 1'b0;
    in_fmt = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_imm = '0;
    exp_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_err_fmt", 32'(err_fmt), 32'd0);
    chk("rst_err_range", 32'(err_range), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Basic encodings and one-cycle latency
    out_ready = 1'b1;
    send(2'b00, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h0050_0093);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    send(2'b01, 5'd0, 5'd3, 5'd2, 3'd2, 32'h1F, 32'h0021_AFA3);
    send(2'b10, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFE00_0FE3);
    chk("no_range_err_in_range", 32'(err_range), 32'd0);
    send(2'b00, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h8000_0093);
    chk("err_range_2048", 32'(err_range), 32'(exp_range_flag));
    drain();
    addr_clr = 1'b1;
    @(posedge clk); #1 addr_clr = 1'b0;
    exp_addr = '0;
    chk("clr_err_range", 32'(err_range), 32'd0);

    // Backpressure: two accepted, then in_ready drops and output holds
    out_ready = 1'b0;
    send(2'b00, 5'd2, 5'd1, 5'd0, 3'd0, 32'd1, 32'h0010_8113);
    send(2'b00, 5'd3, 5'd1, 5'd0, 3'd0, 32'd2, 32'h0020_8193);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("stall_instr", out_instr, 32'h0010_8113);
    chk("stall_addr", 32'(out_addr), 32'd0);
    fork
      send(2'b01, 5'd0, 5'd1, 5'd4, 3'd0, 32'd8, 32'h0040_8423);
      begin repeat (3) @(posedge clk); #2 out_ready = 1'b1; end
    join
    // Continue through the address wrap: 3 -> 0
    send(2'b00, 5'd5, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_0293);
    send(2'b10, 5'd0, 5'd2, 5'd3, 3'd1, 32'hFFFF_F800, 32'h8031_1063);
    drain();
    chk("wrap_next_addr", 32'(exp_addr), 32'd1);

    // Reserved format: consumed, no word, sticky flag
    send(2'b11, 5'd1, 5'd1, 5'd1, 3'd0, 32'd0, 32'd0);
    chk("err_fmt_set", 32'(err_fmt), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("rsv_no_output", 32'(out_valid), 32'd0);
    send(2'b00, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h0050_0093);
    drain();

    // addr_clr coincident with an accept: this word gets 0, the next 1
    addr_clr = 1'b1;
    exp_addr = '0;
    send(2'b00, 5'd7, 5'd0, 5'd0, 3'd0, 32'd0, 32'h0000_0393);
    addr_clr = 1'b0;
    chk("clr_err_fmt", 32'(err_fmt), 32'd0);
    send(2'b00, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h0050_0093);
    drain();

    // Reset discards buffered words
    out_ready = 1'b0;
    send(2'b00, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h0050_0093);
    send(2'b00, 5'd2, 5'd0, 5'd0, 3'd0, 32'd6, 32'h0060_0113);
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    exp_addr = '0;
    out_ready = 1'b1;
    send(2'b00, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h0050_0093);
    drain();
    chk("final_err_range", 32'(err_range), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_word_encoder.md
# instr_word_encoder

Packs instruction fields and an immediate into 32-bit instruction words for the I, S and SB formats, using the same bit layout the core's immediate generator decodes. It sits between a test/boot sequencer and the instruction-memory write port. Output words carry an auto-incrementing write address, and a two-entry output buffer gives full throughput under backpressure.

## Interface
- ADDR_W, 8, width of the instruction-memory word address and write counter
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request this cycle
- in_fmt  in  2  00 = I, 01 = S, 10 = SB, 11 = reserved
- in_rd  in  5  destination register (I only)
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2 (S, SB only)
- in_funct3  in  3  funct3 field
- in_imm  in  32  immediate, two's complement
- out_valid  out  1  encoded word available
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  memory word address for out_instr
- addr_clr  in  1  restart addressing at 0 and clear error flags
- err_fmt  out  1  sticky: reserved format received
- err_range  out  1  sticky: immediate out of encodable range

## Operation
- Accept on `in_valid && in_ready`. Output on `out_valid && out_ready`.
- Encoding:
  - Common fields: `[6:0]` = opcode, `[14:12]` = funct3, `[19:15]` = rs1.
  - I: opcode `0010011`; `[31:20]` = imm[11:0]; `[11:7]` = rd.
  - S: opcode `0100011`; `[31:25]` = imm[11:5]; `[24:20]` = rs2; `[11:7]` = imm[4:0].
  - SB: opcode `1100011`; same field placement as S.
  - rd is ignored for S and SB. rs2 is ignored for I.
- Encodable immediate ranges:
  - I and SB (decoded sign-extended): -2048..2047.
  - S (decoded zero-extended): 0..4095.
  - Upper bits beyond imm[11:0] are always truncated.
- Reserved format: the request is consumed, no word is buffered, and err_fmt is set.
- Output buffer: 2-entry FIFO holding {instr, addr}.
  - `in_ready = (count < 2)`, driven from a register.
  - Order is preserved.
- Write address counter `wr_addr`:
  - Assigned to each word at accept time.
  - Increments by 1 per accepted valid-format request.
  - Wraps from 2^ADDR_W-1 to 0 with no flag.
- `addr_clr`:
  - Sets `wr_addr` to 0 and clears err_fmt/err_range.
  - Buffered words keep their addresses.
  - If a request is accepted in the same cycle, it takes address 0 and the next one takes 1.
- Simultaneous accept and output at count 1: count stays 1.
- At count 2: in_ready is low, so no accept occurs even if out_ready is high that cycle.

## Timing
- Latency: a request accepted at edge N appears on out_valid/out_instr after edge N (visible cycle N+1) when the buffer was empty. No combinational path from in_* to out_*.
- Throughput: 1 word/cycle with out_ready held high.
- out_instr and out_addr are stable while out_valid is high and out_ready is low.
- Reset values: in_ready=0 during rst and 1 the cycle after; out_valid=0; out_instr=0; out_addr=0; err_fmt=0; err_range=0; wr_addr=0; count=0.
- rst mid-operation discards buffered words. rst has priority over addr_clr and all handshakes.
- Sticky errors set at the accept edge and are visible the next cycle.

## Configuration
- `INSTR_ENC_RANGE_CHECK_EN`:
  - Defined: range comparators are present; an out-of-range immediate still emits the truncated word and sets err_range.
  - Undefined: comparators are removed and err_range is tied to 0.
  - Encoding is identical in both cases.

## Structure
- Shared package `instr_enc_pkg`:
  - Format enum: FMT_I, FMT_S, FMT_SB, FMT_RSV.
  - Opcode constants: OPC_I, OPC_S, OPC_SB.
  - Immediate range constants.
- Sub-module `instr_pack`: combinational field packer and range check.
- Top level owns the FIFO, counter and flags.

## Test plan
- I: rd=1, rs1=0, funct3=0, imm=5 -> out_instr=0x00500093, out_addr=0.
- S: rs1=3, rs2=2, funct3=2, imm=0x1F -> 0x0021AFA3. SB: rs1=0, rs2=0, funct3=0, imm=-1 -> 0xFE000FE3.
- Range, macro defined: I with rd=1, imm=2048 -> 0x80000093 and err_range=1 next cycle. Macro undefined: err_range stays 0.
- Backpressure: out_ready=0 with 3 requests -> in_ready low after 2 accepts. Then out_ready=1 -> words in order at addresses 0, 1, 2.
- Wrap with ADDR_W=2: 5 requests -> addresses 0, 1, 2, 3, 0. in_fmt=11 -> no output, err_fmt=1. addr_clr -> flags cleared and next address 0.
- rst asserted with 2 words buffered -> out_valid=0 next cycle and the next accepted word gets address 0.
